// File: rtl/lzss_enc_search_pipe_if.sv
// Purpose: handshake and candidate/result bus for the LZSS match-search select tree.
// Latency: none, this is wiring only.
// Backpressure: o_ready/i_ready flow control travels with the bus.
interface lzss_enc_search_pipe_if #(
    parameter int pReferenceSize = 64,
    parameter int pOffsetWidth   = 6,
    parameter int pLengthWidth   = 3
);
    logic                                   i_valid;
    logic                                   o_ready;
    logic [pOffsetWidth*pReferenceSize-1:0] i_offset;
    logic [pLengthWidth*pReferenceSize-1:0] i_length;
    logic [pReferenceSize-1:0]              i_last;
    logic                                   o_valid;
    logic                                   i_ready;
    logic [pOffsetWidth-1:0]                o_offset;
    logic [pLengthWidth-1:0]                o_length;
    logic                                   o_last;
    logic                                   o_hit;

    // Candidate producer and result consumer side
    modport master (
        output i_valid, i_offset, i_length, i_last, i_ready,
        input  o_ready, o_valid, o_offset, o_length, o_last, o_hit
    );

    // Search pipeline side
    modport slave (
        input  i_valid, i_offset, i_length, i_last, i_ready,
        output o_ready, o_valid, o_offset, o_length, o_last, o_hit
    );
endinterface

// File: rtl/lzss_enc_search_pipe.sv
// Purpose: pipelined compare-select tree picking the longest match among candidate entries.
// Latency: pOffsetWidth cycles from acceptance to result, plus one cycle per stall cycle.
// Backpressure: whole tree freezes while a result is held and i_ready is low; o_ready mirrors that.
module lzss_enc_search_pipe #(
    parameter int pReferenceSize = 64,
    parameter int pOffsetWidth   = 6,
    parameter int pLengthWidth   = 3,
    parameter int pMinLength     = 2,
    parameter int pTieMode       = 0
) (
    input  logic                 clk,
    input  logic                 rst_x,
    input  logic                 i_clear,
    lzss_enc_search_pipe_if.slave bus
);
    // Tree depth equals the offset width; leaves are padded up to 2^D.
    localparam int D  = pOffsetWidth;
    localparam int NN = 1 << D;
    localparam logic [pLengthWidth-1:0] MIN_LEN = pLengthWidth'(pMinLength);

    // Leaves are combinational slices of the input vector.
    logic [pOffsetWidth-1:0] leaf_off  [NN];
    logic [pLengthWidth-1:0] leaf_len  [NN];
    logic                    leaf_last [NN];

    // Heap-indexed tree nodes: node n has children 2n and 2n+1, root is node 1.
    // Depth d lives in pipeline stage D-1-d, so the root is the last stage.
    logic [pOffsetWidth-1:0] node_off_q  [1:NN-1];
    logic [pLengthWidth-1:0] node_len_q  [1:NN-1];
    logic                    node_last_q [1:NN-1];
    logic [pOffsetWidth-1:0] nxt_off     [1:NN-1];
    logic [pLengthWidth-1:0] nxt_len     [1:NN-1];
    logic                    nxt_last    [1:NN-1];

    logic [D-1:0] vld_q;
    logic         en;
    logic         win_hit;

    for (genvar k = 0; k < NN; k++) begin : g_leaf
        if (k < pReferenceSize) begin : g_real
            assign leaf_off[k]  = bus.i_offset[k*pOffsetWidth +: pOffsetWidth];
            assign leaf_len[k]  = bus.i_length[k*pLengthWidth +: pLengthWidth];
            assign leaf_last[k] = bus.i_last[k];
        end else begin : g_pad
            assign leaf_off[k]  = '0;
            assign leaf_len[k]  = '0;
            assign leaf_last[k] = 1'b0;
        end
    end

    for (genvar d = 0; d < D; d++) begin : g_depth
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            localparam int N    = (1 << d) + j;
            localparam int SPAN = 1 << (D - 1 - d);
            // Right subtree made only of padding never wins, so padding cannot beat a real tie.
            localparam bit RPAD = ((2 * j + 1) * SPAN) >= pReferenceSize;

            logic [pOffsetWidth-1:0] l_off, r_off;
            logic [pLengthWidth-1:0] l_len, r_len;
            logic                    l_last, r_last;
            logic                    pick_r;

            if (d == D - 1) begin : g_from_leaf
                assign l_off  = leaf_off[2*j];
                assign l_len  = leaf_len[2*j];
                assign l_last = leaf_last[2*j];
                assign r_off  = leaf_off[2*j+1];
                assign r_len  = leaf_len[2*j+1];
                assign r_last = leaf_last[2*j+1];
            end else begin : g_from_node
                assign l_off  = node_off_q[2*N];
                assign l_len  = node_len_q[2*N];
                assign l_last = node_last_q[2*N];
                assign r_off  = node_off_q[2*N+1];
                assign r_len  = node_len_q[2*N+1];
                assign r_last = node_last_q[2*N+1];
            end

            // Longer length wins; equal lengths go to the higher index unless pTieMode selects lower.
            assign pick_r      = !RPAD && ((pTieMode == 0) ? (r_len >= l_len) : (r_len > l_len));
            assign nxt_off[N]  = pick_r ? r_off  : l_off;
            assign nxt_len[N]  = pick_r ? r_len  : l_len;
            assign nxt_last[N] = pick_r ? r_last : l_last;
        end
    end

    assign bus.o_valid = vld_q[D-1];
    assign en          = !vld_q[D-1] || bus.i_ready;
    assign bus.o_ready = en;

    // Tree registers: async reset, synchronous flush, otherwise advance only on en
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            vld_q <= '0;
            for (int n = 1; n < NN; n++) begin
                node_off_q[n]  <= '0;
                node_len_q[n]  <= '0;
                node_last_q[n] <= 1'b0;
            end
        end else if (i_clear) begin
            vld_q <= '0;
            for (int n = 1; n < NN; n++) begin
                node_off_q[n]  <= '0;
                node_len_q[n]  <= '0;
                node_last_q[n] <= 1'b0;
            end
        end else if (en) begin
            vld_q[0] <= bus.i_valid;
            for (int s = 1; s < D; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
            for (int n = 1; n < NN; n++) begin
                node_off_q[n]  <= nxt_off[n];
                node_len_q[n]  <= nxt_len[n];
                node_last_q[n] <= nxt_last[n];
            end
        end
    end

    // Short matches are reported as a miss with zeroed offset/length; last always follows the winner.
    assign win_hit      = vld_q[D-1] && (node_len_q[1] >= MIN_LEN);
    assign bus.o_hit    = win_hit;
    assign bus.o_length = win_hit ? node_len_q[1] : '0;
    assign bus.o_offset = win_hit ? node_off_q[1] : '0;
    assign bus.o_last   = vld_q[D-1] && node_last_q[1];
endmodule

// File: tb/tb_lzss_enc_search_pipe.sv
// Purpose: self-checking bench for the match-search select tree (two tie modes plus a small padded tree).
// Latency: checks 6-cycle default latency and 3-cycle latency of the small configuration.
// Backpressure: random i_ready with a forced 3-cycle stall, clear and mid-stream reset.
module tb_lzss_enc_search_pipe;
    localparam int RS  = 64;
    localparam int OW  = 6;
    localparam int LW  = 3;
    localparam int RS2 = 5;
    localparam int OW2 = 3;

    typedef struct packed {
        logic [OW-1:0] off;
        logic [LW-1:0] len;
        logic          last;
        logic          hit;
    } res_t;

    logic clk = 1'b0;
    logic rst_x;
    logic i_clear;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lzss_enc_search_pipe_if #(.pReferenceSize(RS),  .pOffsetWidth(OW),  .pLengthWidth(LW)) if0 ();
    lzss_enc_search_pipe_if #(.pReferenceSize(RS),  .pOffsetWidth(OW),  .pLengthWidth(LW)) if1 ();
    lzss_enc_search_pipe_if #(.pReferenceSize(RS2), .pOffsetWidth(OW2), .pLengthWidth(LW)) if2 ();

    lzss_enc_search_pipe #(.pTieMode(0)) dut0 (
        .clk(clk), .rst_x(rst_x), .i_clear(i_clear), .bus(if0.slave));
    lzss_enc_search_pipe #(.pTieMode(1)) dut1 (
        .clk(clk), .rst_x(rst_x), .i_clear(i_clear), .bus(if1.slave));
    lzss_enc_search_pipe #(.pReferenceSize(RS2), .pOffsetWidth(OW2), .pLengthWidth(LW),
                           .pMinLength(0), .pTieMode(0)) dut2 (
        .clk(clk), .rst_x(rst_x), .i_clear(i_clear), .bus(if2.slave));

    // dut1 sees exactly the stimulus of dut0, only its tie rule differs
    assign if1.i_valid  = if0.i_valid;
    assign if1.i_offset = if0.i_offset;
    assign if1.i_length = if0.i_length;
    assign if1.i_last   = if0.i_last;
    assign if1.i_ready  = if0.i_ready;

    logic [OW-1:0] v_off  [RS];
    logic [LW-1:0] v_len  [RS];
    logic          v_last [RS];
    res_t          q0[$];
    res_t          q1[$];
    res_t          held0;
    logic          held_v = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: scan all real entries; the longest wins, ties go to the last (mode 0) or first (mode 1) seen.
    function automatic res_t ref_model(input int tie_mode);
        int   best;
        res_t r;
        best = 0;
        for (int k = 1; k < RS; k++) begin
            if (int'(v_len[k]) > int'(v_len[best]) ||
                (int'(v_len[k]) == int'(v_len[best]) && tie_mode == 0))
                best = k;
        end
        r.hit  = int'(v_len[best]) >= 2;
        r.len  = r.hit ? v_len[best] : '0;
        r.off  = r.hit ? v_off[best] : '0;
        r.last = v_last[best];
        return r;
    endfunction

    function automatic res_t out0();
        res_t r;
        r.off = if0.o_offset; r.len = if0.o_length; r.last = if0.o_last; r.hit = if0.o_hit;
        return r;
    endfunction

    function automatic res_t out1();
        res_t r;
        r.off = if1.o_offset; r.len = if1.o_length; r.last = if1.o_last; r.hit = if1.o_hit;
        return r;
    endfunction

    task automatic drive_vec();
        for (int k = 0; k < RS; k++) begin
            if0.i_offset[k*OW +: OW] = v_off[k];
            if0.i_length[k*LW +: LW] = v_len[k];
            if0.i_last[k]            = v_last[k];
        end
    endtask

    task automatic rand_vec();
        for (int k = 0; k < RS; k++) begin
            v_off[k]  = OW'($urandom);
            v_len[k]  = LW'($urandom_range(0, 7));
            v_last[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic index_vec();
        for (int k = 0; k < RS; k++) begin
            v_off[k]  = OW'(k);
            v_len[k]  = '0;
            v_last[k] = 1'b0;
        end
    endtask

    // One clock of streaming: record accepted vectors, check held outputs and delivered results.
    task automatic cycle();
        res_t got, exp;
        #1;
        if (if0.i_valid && if0.o_ready && !i_clear) begin
            q0.push_back(ref_model(0));
            q1.push_back(ref_model(1));
        end
        got = out0();
        if (held_v) begin
            chk("stall_vld", if0.o_valid, 1);
            chk("stall_hold", got, held0);
        end
        if (if0.o_valid && !if0.i_ready)
            chk("stall_rdy", if0.o_ready, 0);
        if (if0.o_valid && if0.i_ready) begin
            chk("res0_expected", q0.size() > 0, 1);
            if (q0.size() > 0) begin
                exp = q0.pop_front();
                chk("res0", got, exp);
            end
        end
        if (if1.o_valid && if1.i_ready) begin
            chk("res1_expected", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                exp = q1.pop_front();
                chk("res1", out1(), exp);
            end
        end
        held_v = if0.o_valid && !if0.i_ready;
        held0  = got;
        @(posedge clk);
        #1;
    endtask

    // Offer one vector with i_ready high and wait (bounded) for its result.
    task automatic run_one(output int lat, output res_t r0, output res_t r1);
        drive_vec();
        if0.i_valid = 1'b1;
        if0.i_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.i_valid = 1'b0;
        lat = 0;
        r0  = '0;
        r1  = '0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (if0.o_valid) begin
                lat = c;
                r0  = out0();
                r1  = out1();
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    int   lat;
    res_t r0, r1;

    initial begin
        rst_x        = 1'b0;
        i_clear      = 1'b0;
        if0.i_valid  = 1'b0;
        if0.i_ready  = 1'b1;
        if0.i_offset = '0;
        if0.i_length = '0;
        if0.i_last   = '0;
        if2.i_valid  = 1'b0;
        if2.i_ready  = 1'b1;
        if2.i_offset = '0;
        if2.i_length = '0;
        if2.i_last   = '0;
        #12;
        chk("rst_vld", if0.o_valid, 0);
        chk("rst_off", if0.o_offset, 0);
        chk("rst_len", if0.o_length, 0);
        chk("rst_last", if0.o_last, 0);
        chk("rst_hit", if0.o_hit, 0);
        chk("rst_rdy", if0.o_ready, 1);
        chk("rst_vld2", if2.o_valid, 0);
        @(negedge clk);
        rst_x = 1'b1;
        @(posedge clk);
        #1;

        // Single match at entry 37
        index_vec();
        v_len[37] = 3'd5;
        run_one(lat, r0, r1);
        chk("lat_default", lat, 6);
        chk("e37_off", r0.off, 37);
        chk("e37_len", r0.len, 5);
        chk("e37_hit", r0.hit, 1);
        chk("e37_off_t1", r1.off, 37);

        // Tie between entries 3 and 50
        index_vec();
        for (int k = 0; k < RS; k++) v_len[k] = LW'($urandom_range(0, 3));
        v_len[3]  = 3'd4;
        v_len[50] = 3'd4;
        run_one(lat, r0, r1);
        chk("tie_t0_off", r0.off, 50);
        chk("tie_t1_off", r1.off, 3);
        chk("tie_t0_len", r0.len, 4);

        // Best match below minimum length
        index_vec();
        v_len[9]  = 3'd1;
        v_last[9] = 1'b1;
        run_one(lat, r0, r1);
        chk("short_hit", r0.hit, 0);
        chk("short_len", r0.len, 0);
        chk("short_off", r0.off, 0);
        chk("short_last", r0.last, 1);
        chk("short_last_t1", r1.last, 1);

        // Five entries in an 8-leaf tree, all lengths zero
        for (int k = 0; k < RS2; k++) if2.i_offset[k*OW2 +: OW2] = OW2'(k);
        if2.i_valid = 1'b1;
        @(posedge clk);
        #1;
        if2.i_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (if2.o_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("small_lat", lat, 3);
        chk("small_off", if2.o_offset, 4);
        chk("small_hit", if2.o_hit, 1);
        chk("small_len", if2.o_length, 0);
        @(posedge clk);
        #1;

        // Random stream with random backpressure and a forced 3-cycle stall
        for (int c = 0; c < 200; c++) begin
            rand_vec();
            drive_vec();
            if0.i_valid = (c >= 80 && c < 96) ? 1'b1 : ($urandom_range(0, 9) < 7);
            if0.i_ready = (c >= 90 && c < 93) ? 1'b0 : ($urandom_range(0, 4) != 0);
            cycle();
        end
        if0.i_valid = 1'b0;
        if0.i_ready = 1'b1;
        for (int c = 0; c < 12; c++) cycle();
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        // Flush with four vectors in flight and a fifth offered alongside
        for (int c = 0; c < 4; c++) begin
            rand_vec();
            drive_vec();
            if0.i_valid = 1'b1;
            cycle();
        end
        rand_vec();
        drive_vec();
        i_clear = 1'b1;
        cycle();
        i_clear     = 1'b0;
        if0.i_valid = 1'b0;
        q0.delete();
        q1.delete();
        held_v = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("clr_vld0", if0.o_valid, 0);
            chk("clr_vld1", if1.o_valid, 0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a stream
        for (int c = 0; c < 8; c++) begin
            rand_vec();
            drive_vec();
            if0.i_valid = 1'b1;
            cycle();
        end
        #2;
        chk("pre_rst_vld", if0.o_valid, 1);
        rst_x       = 1'b0;
        if0.i_valid = 1'b0;
        #1;
        chk("arst_vld", if0.o_valid, 0);
        chk("arst_off", if0.o_offset, 0);
        chk("arst_len", if0.o_length, 0);
        chk("arst_last", if0.o_last, 0);
        chk("arst_hit", if0.o_hit, 0);
        chk("arst_rdy", if0.o_ready, 1);
        @(negedge clk);
        rst_x = 1'b1;
        q0.delete();
        q1.delete();
        held_v = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("post_rst_vld", if0.o_valid, 0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lzss_enc_search_pipe.md
LZSS_ENC_SEARCH_PIPE -- requirements
Module: lzss_enc_search_pipe

Interface
REQ-001 SHALL have parameter pReferenceSize, default 64: number of candidate entries; any value 2..256, power of two not required.
REQ-002 SHALL have parameter pOffsetWidth, default 6: offset width per entry and tree depth D; pReferenceSize <= 2^D.
REQ-003 SHALL have parameter pLengthWidth, default 3: match-length width per entry.
REQ-004 SHALL have parameter pMinLength, default 2: shortest reportable match; must be <= 2^pLengthWidth-1.
REQ-005 SHALL have parameter pTieMode, default 0: tie winner; 0 = higher-index entry, 1 = lower-index entry.
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_x  input  1  reset; one clock; asynchronous, active-low.
REQ-008 SHALL have port i_clear  input  1  synchronous flush of all pipeline state.
REQ-009 SHALL have port i_valid  input  1  candidate vector valid.
REQ-010 SHALL have port o_ready  output  1  block accepts a vector this cycle.
REQ-011 SHALL have port i_offset  input  pOffsetWidth*pReferenceSize  packed offsets, entry k at [k*pOffsetWidth +: pOffsetWidth].
REQ-012 SHALL have port i_length  input  pLengthWidth*pReferenceSize  packed lengths, same packing.
REQ-013 SHALL have port i_last  input  pReferenceSize  per-entry last-code flag.
REQ-014 SHALL have port o_valid  output  1  result valid.
REQ-015 SHALL have port i_ready  input  1  downstream accepts result.
REQ-016 SHALL have port o_offset  output  pOffsetWidth  winning offset.
REQ-017 SHALL have port o_length  output  pLengthWidth  winning length, 0 if below pMinLength.
REQ-018 SHALL have port o_last  output  1  winning entry's last flag.
REQ-019 SHALL have port o_hit  output  1  winning length >= pMinLength.

Function
REQ-020 SHALL implement a binary compare-select tree of D registered stages; stage s holds 2^(D-1-s) nodes, each with offset, length, last, plus one valid bit per stage.
REQ-021 SHALL pad leaf positions pReferenceSize..2^D-1 with length 0, offset 0, last 0; a padded leaf never beats a real entry of equal length.
REQ-022 SHALL select at each node the larger length; on equal lengths pick the higher-index child if pTieMode=0, lower-index child if pTieMode=1.
REQ-023 SHALL carry offset and last together with the selected length.
REQ-024 SHALL define advance enable en = !o_valid || i_ready; o_ready = en; all stages shift only when en=1, otherwise hold.
REQ-025 SHALL capture a vector when i_valid && o_ready; stage-0 valid loads i_valid on every en cycle, so bubbles propagate and are not compacted.
REQ-026 SHALL present the result D cycles after acceptance when never stalled; each stall cycle adds exactly one cycle.
REQ-027 SHALL hold o_valid, o_offset, o_length, o_last, o_hit stable while o_valid && !i_ready.
REQ-028 SHALL drive o_hit = (winning length >= pMinLength); when o_hit=0, o_length=0 and o_offset=0; o_last still reflects the winner.
REQ-029 SHALL sustain throughput of one vector per cycle while i_ready=1.
REQ-030 SHALL, on i_clear=1, zero all stage data and valids next edge regardless of en; a vector offered the same cycle is discarded; i_clear takes priority over i_valid and i_ready.

Reset
REQ-031 SHALL on rst_x=0 asynchronously zero all stage registers: o_valid=0, o_offset=0, o_length=0, o_last=0, o_hit=0; o_ready=1 after reset.
REQ-032 SHALL drop any in-flight vectors on reset mid-operation, producing no result for them.

Verification
REQ-033 Defaults, all lengths 0 except entry 37 length 5 offset 37, i_ready=1 -> o_valid exactly 6 cycles later, o_offset=37, o_length=5, o_hit=1.
REQ-034 Tie: entries 3 and 50 length 4, pTieMode=0 -> o_offset=50; pTieMode=1 -> o_offset=3.
REQ-035 pMinLength=2, max length 1 at entry 9 with last=1 -> o_hit=0, o_length=0, o_offset=0, o_last=1.
REQ-036 pReferenceSize=5, pOffsetWidth=3, all lengths 0, pTieMode=0 -> o_offset=4 (padded leaves never win), latency 3.
REQ-037 Back-to-back vectors with i_ready low for 3 cycles mid-stream -> no loss or duplication, outputs held while stalled, order preserved, o_ready=0 during stall.
REQ-038 i_clear asserted with 4 vectors in flight -> o_valid=0 from next cycle, no stale result later; rst_x pulsed mid-stream -> all outputs 0 immediately.
